// File: rtl/fht_input_loader_if.sv
// Sample-stream, start handshake and shared bank write-port bundle for fht_input_loader.
// The slave modport is the loader's view; the master modport is the feeder/FHT-core side.
`timescale 1ns/1ps

interface fht_input_loader_if #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
);
  logic [D_BIT-1:0] iDATA;
  logic             iVALID;
  logic             oREADY;
  logic             iFHT_RDY;
  logic             oSTART;
  logic [D_BIT-1:0] oDATA;
  logic [A_BIT-1:0] oADDR;
  logic [3:0]       oWE;
  logic             oBUSY;

  modport master (
    output iDATA, iVALID, iFHT_RDY,
    input  oREADY, oSTART, oDATA, oADDR, oWE, oBUSY
  );

  modport slave (
    input  iDATA, iVALID, iFHT_RDY,
    output oREADY, oSTART, oDATA, oADDR, oWE, oBUSY
  );
endinterface

// File: rtl/fht_input_loader.sv
// Loads one N = 4*2^A_BIT sample frame into the four FHT RAM banks, then starts the core.
// Define FHT_LOAD_BITREV_EN for bit-reversed placement; otherwise samples land in natural order.
`timescale 1ns/1ps

module fht_input_loader #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input logic               iCLK,
  input logic               iRESET,
  fht_input_loader_if.slave bus
);

  localparam int             K_BIT  = A_BIT + 2;
  localparam logic [K_BIT-1:0] K_LAST = '1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_FIRE      = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  logic [2:0]       r_state;
  logic [K_BIT-1:0] r_k;
  logic [D_BIT-1:0] r_data;
  logic [A_BIT-1:0] r_addr;
  logic [3:0]       r_we;
  logic             r_start;
  logic             r_busy;
  logic [2:0]       r_wait;

  logic             w_ready;
  logic             w_xfer;
  logic [K_BIT-1:0] w_r;
  logic [1:0]       w_bank;
  logic [A_BIT-1:0] w_addr;

  // A frame only accepts samples while the core is idle; a core started
  // elsewhere mid-frame freezes k until it reports ready again.
  assign w_ready = ~iRESET & bus.iFHT_RDY &
                   ((r_state == S_IDLE) | (r_state == S_LOAD));
  assign w_xfer  = bus.iVALID & w_ready;

`ifdef FHT_LOAD_BITREV_EN
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned and infers a latch.
    w_r = '0;
    for (int i = 0; i < K_BIT; i++) begin
      w_r[i] = r_k[K_BIT-1-i];
    end
  end
`else
  assign w_r = r_k;
`endif

  assign w_bank = w_r[1:0];
  assign w_addr = w_r[K_BIT-1:2];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_k    <= '0;
      r_data <= '0;
      r_addr <= '0;
      r_we   <= '0;
    end else begin
      r_we <= '0;
      if (w_xfer) begin
        r_k    <= r_k + 1'b1;
        r_data <= bus.iDATA;
        r_addr <= w_addr;
        r_we   <= 4'b0001 << w_bank;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_xfer && (r_k == K_LAST)) begin
            r_state <= S_FIRE;
          end
        end
        S_FIRE: begin
          r_start <= 1'b1;
          r_wait  <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A start the core missed is retried once; r_wait then saturates.
          if (!bus.iFHT_RDY) begin
            r_state <= S_WAIT_DONE;
          end else if (r_wait != 3'd4) begin
            r_wait <= r_wait + 3'd1;
            if (r_wait == 3'd3) begin
              r_start <= 1'b1;
            end
          end
        end
        S_WAIT_DONE: begin
          if (bus.iFHT_RDY) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oREADY = w_ready;
  assign bus.oSTART = r_start;
  assign bus.oDATA  = r_data;
  assign bus.oADDR  = r_addr;
  assign bus.oWE    = r_we;
  assign bus.oBUSY  = r_busy;

  // Bank ports are shared with the core's mixer: at most one bank per cycle, never during a start.
  a_we_onehot: assert property (@(posedge iCLK) disable iff (iRESET) $onehot0(bus.oWE));
  a_we_vs_start: assert property (@(posedge iCLK) disable iff (iRESET)
                                  !((bus.oWE != 4'b0) && bus.oSTART));
  a_start_phase: assert property (@(posedge iCLK) disable iff (iRESET)
                                  bus.oSTART |-> (r_state == S_WAIT_BUSY));

endmodule

// File: tb/tb_fht_input_loader.sv
// Scoreboard bench for fht_input_loader: expected bank writes are queued at each transfer
// and popped when oWE fires; start/ready/busy sequencing is checked around each frame.
`timescale 1ns/1ps

module tb_fht_input_loader;

  localparam int A_BIT = 8;
  localparam int D_BIT = 16;
  localparam int N     = 1 << (A_BIT + 2);
  localparam int DEPTH = 1 << A_BIT;

  typedef struct {
    int               k;
    int               bank;
    int               addr;
    logic [D_BIT-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fht_input_loader_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

  fht_input_loader #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus)
  );

  wr_t              exp_q[$];
  int               start_q[$];
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               last_we_cyc = -1;
  int               wr_cnt = 0;
  int               tb_k = 0;
  int               obs_bank[N];
  int               obs_addr[N];
  logic [D_BIT-1:0] exp_mem[4][DEPTH];
  logic [D_BIT-1:0] dut_mem[4][DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void map_k(input int k, output int bank, output int addr);
    int r;
    r = 0;
`ifdef FHT_LOAD_BITREV_EN
    for (int i = 0; i < A_BIT + 2; i++) begin
      if ((k & (1 << i)) != 0) r |= 1 << (A_BIT + 1 - i);
    end
`else
    r = k;
`endif
    bank = r & 3;
    addr = r >> 2;
  endfunction

  // Write-port monitor: every oWE cycle must match the oldest queued transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.oSTART) start_q.push_back(cyc);
        if (bus.oWE != 4'b0) begin : wr
          int  b;
          wr_t e;
          check("we_onehot", $countones(bus.oWE), 1);
          b = 0;
          for (int i = 0; i < 4; i++) if (bus.oWE[i]) b = i;
          wr_cnt++;
          last_we_cyc = cyc;
          dut_mem[b][bus.oADDR] = bus.oDATA;
          if (exp_q.size() == 0) begin
            check("we_spurious", bus.oWE, 0);
          end else begin
            e = exp_q.pop_front();
            obs_bank[e.k] = b;
            obs_addr[e.k] = int'(bus.oADDR);
            check("wr_bank", b, e.bank);
            check("wr_addr", bus.oADDR, e.addr);
            check("wr_data", bus.oDATA, e.data);
          end
        end
      end
    end
  end

  task automatic new_frame();
    wr_cnt = 0;
    start_q.delete();
  endtask

  task automatic send_samples(input int count, input int gap_pct);
    int  sent = 0;
    int  budget = 0;
    int  b, a;
    wr_t e;
    while (sent < count && budget < 20 * count + 100) begin
      @(negedge clk);
      budget++;
      bus.iVALID = ($urandom_range(99) >= gap_pct);
      bus.iDATA  = D_BIT'($urandom);
      #1;
      if (bus.iVALID && bus.oREADY) begin
        map_k(tb_k, b, a);
        e = '{k: tb_k, bank: b, addr: a, data: bus.iDATA};
        exp_q.push_back(e);
        exp_mem[b][a] = bus.iDATA;
        tb_k = (tb_k + 1) % N;
        sent++;
      end
    end
    check("send_budget", sent, count);
    @(negedge clk);
    bus.iVALID = 1'b0;
  endtask

  // Core started by another source mid-frame: loader must stall with k frozen.
  task automatic ready_dip();
    @(negedge clk);
    bus.iFHT_RDY = 1'b0;
    bus.iVALID   = 1'b1;
    #1;
    check("ready_dip", bus.oREADY, 0);
    check("busy_mid", bus.oBUSY, 1);
    repeat (3) @(negedge clk);
    bus.iFHT_RDY = 1'b1;
    bus.iVALID   = 1'b0;
  endtask

  task automatic finish_frame(input bit missed);
    bit seen = 1'b0;
    int t0 = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (bus.oSTART) begin
        seen = 1'b1;
        t0   = cyc;
      end
    end
    check("start_seen", seen, 1);
    check("start_after_we", t0 - last_we_cyc, 1);
    check("frame_writes", wr_cnt, N);
    if (missed) repeat (8) @(negedge clk);
    @(negedge clk);
    bus.iFHT_RDY = 1'b0;
    bus.iVALID   = 1'b1;
    #1;
    check("start_width", bus.oSTART, 0);
    repeat (6) @(negedge clk);
    check("ready_hold", bus.oREADY, 0);
    check("busy_hold", bus.oBUSY, 1);
    bus.iFHT_RDY = 1'b1;
    bus.iVALID   = 1'b0;
    #1;
    check("ready_wait_done", bus.oREADY, 0);
    @(negedge clk);
    #1;
    check("busy_clear", bus.oBUSY, 0);
    check("ready_idle", bus.oREADY, 1);
    check("start_count", start_q.size(), missed ? 2 : 1);
    if (missed && start_q.size() == 2) check("restart_gap", start_q[1] - start_q[0], 4);
  endtask

  task automatic chk_map(input int k, input int b, input int a);
    check($sformatf("map_bank_k%0d", k), obs_bank[k], b);
    check($sformatf("map_addr_k%0d", k), obs_addr[k], a);
  endtask

  task automatic compare_mem(input string tag);
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        check($sformatf("%s_b%0d_a%0d", tag, b, a), dut_mem[b][a], exp_mem[b][a]);
      end
    end
  endtask

  initial begin
    bus.iVALID   = 1'b0;
    bus.iDATA    = '0;
    bus.iFHT_RDY = 1'b1;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.oREADY, 0);
    check("rst_start", bus.oSTART, 0);
    check("rst_we", bus.oWE, 0);
    check("rst_data", bus.oDATA, 0);
    check("rst_addr", bus.oADDR, 0);
    check("rst_busy", bus.oBUSY, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", bus.oREADY, 1);

    // Frame 1: back-to-back samples, prompt core response.
    new_frame();
    send_samples(N, 0);
    finish_frame(1'b0);
`ifdef FHT_LOAD_BITREV_EN
    chk_map(1, 0, 128);
    chk_map(2, 0, 64);
    chk_map(256, 2, 0);
    chk_map(512, 1, 0);
    chk_map(1023, 3, 255);
`else
    chk_map(1, 1, 0);
    chk_map(5, 1, 1);
    chk_map(1023, 3, 255);
`endif

    // Frame 2: random gaps, a foreign core run mid-frame, and a missed start.
    new_frame();
    send_samples(300, 40);
    ready_dip();
    send_samples(N - 300, 40);
    finish_frame(1'b1);
    compare_mem("mem2");

    // Frame 3: reset in the middle of loading discards the partial frame.
    new_frame();
    send_samples(500, 20);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", bus.oREADY, 0);
    check("midrst_we", bus.oWE, 0);
    check("midrst_busy", bus.oBUSY, 0);
    check("midrst_data", bus.oDATA, 0);
    check("midrst_addr", bus.oADDR, 0);
    check("midrst_pending", exp_q.size(), 0);
    @(negedge clk);
    rst  = 1'b0;
    tb_k = 0;
    repeat (10) @(negedge clk);
    check("midrst_no_start", start_q.size(), 0);
    check("midrst_idle_busy", bus.oBUSY, 0);
    check("midrst_idle_ready", bus.oREADY, 1);

    // Frame 4: fresh frame after reset must start from k = 0.
    new_frame();
    send_samples(N, 10);
    finish_frame(1'b0);
    chk_map(0, 0, 0);
    compare_mem("mem4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    check("watchdog", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
